sentinel_key_courier: RTL and testbench

Transmitter end of the Sentinel key interface. It accepts an 8-bit authorization key over a valid/ready handshake and sends it to a Sentinel gate MSB-first over a framed 3-wire serial link (sclk, sdata, frame). After a settle window it samples the gate's status line and reports grant or deny. Consecutive denials are counted, and MAX_FAILS denials enforce a hardware lockout. It sits on the presenter board, facing the gate's key port and status array.

---
 rtl/sentinel_key_courier.sv | 151 +++++++++++++++
 tb/tb_sentinel_key_courier.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sentinel_key_courier.sv
// Transmitter end of the Sentinel key interface: serializes an 8-bit key over a
// framed 3-wire link, samples the gate's status, and enforces a denial lockout.
module sentinel_key_courier #(
  parameter int CLK_DIV        = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] key_data,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       link_sclk,
  output logic       link_sdata,
  output logic       link_frame,
  input  logic       gate_status,
  output logic       result_valid,
  output logic       result_granted,
  output logic [1:0] fail_count,
  output logic       locked_out,
  output logic       busy
);

  localparam int PERIOD   = 2 * CLK_DIV;
  localparam int SPAN_A   = (PERIOD > SETTLE_CYCLES) ? PERIOD : SETTLE_CYCLES;
  localparam int CNT_SPAN = (SPAN_A > LOCKOUT_CYCLES) ? SPAN_A : LOCKOUT_CYCLES;
  localparam int CNT_W    = $clog2(CNT_SPAN);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF        = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]       FAIL_MAX    = 2'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE, S_FRAME_START, S_SHIFT, S_SETTLE, S_REPORT, S_LOCKOUT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [1:0]       r_sync;
  logic             r_status;
  logic [1:0]       r_fail;

  logic       w_handshake;
  logic       w_period_end;
  logic [1:0] w_fail_inc;
  logic       w_deny_locks;

  assign w_handshake  = key_valid & key_ready;
  assign w_period_end = (r_cnt == PERIOD_LAST);
  assign w_fail_inc   = (r_fail == FAIL_MAX) ? r_fail : r_fail + 2'd1;
  assign w_deny_locks = !r_status && (w_fail_inc == FAIL_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= S_IDLE;
    else if (ena) r_state <= w_next;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:        if (w_handshake) w_next = S_FRAME_START;
      S_FRAME_START: if (w_period_end) w_next = S_SHIFT;
      S_SHIFT:       if (w_period_end && r_bit == 3'd7) w_next = S_SETTLE;
      S_SETTLE:      if (r_cnt == SETTLE_LAST) w_next = S_REPORT;
      S_REPORT:      w_next = w_deny_locks ? S_LOCKOUT : S_IDLE;
      S_LOCKOUT:     if (r_cnt == LOCK_LAST) w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  // The status line is asynchronous to clk; it runs free so the sample is fresh on resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], gate_status};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_bit    <= 3'd0;
      r_shift  <= 8'd0;
      r_status <= 1'b0;
      r_fail   <= 2'd0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_handshake) begin
            r_shift <= key_data;
            r_bit   <= 3'd0;
          end
        end
        S_FRAME_START: r_cnt <= w_period_end ? '0 : r_cnt + CNT_ONE;
        S_SHIFT: begin
          if (w_period_end) begin
            r_cnt   <= '0;
            r_shift <= {r_shift[6:0], 1'b0};
            r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt    <= '0;
            r_status <= r_sync[1];
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_REPORT: begin
          r_cnt  <= '0;
          r_fail <= r_status ? 2'd0 : w_fail_inc;
        end
        S_LOCKOUT: begin
          if (r_cnt == LOCK_LAST) begin
            r_cnt  <= '0;
            r_fail <= 2'd0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Outputs decode from held state, so they freeze along with it while ena is low.
  always_comb begin
    key_ready      = (r_state == S_IDLE) & ena;
    link_frame     = (r_state == S_FRAME_START) || (r_state == S_SHIFT);
    link_sclk      = (r_state == S_SHIFT) && (r_cnt >= HALF);
    link_sdata     = (r_state == S_SHIFT) && r_shift[7];
    result_valid   = (r_state == S_REPORT);
    result_granted = (r_state == S_REPORT) && r_status;
    fail_count     = r_fail;
    locked_out     = (r_state == S_LOCKOUT);
    busy           = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_sentinel_key_courier.sv
// Self-checking bench for sentinel_key_courier: table-driven transactions,
// hand-written corner sequences, and randomized traffic against a denial-count model.
module tb_sentinel_key_courier;

  localparam int MAX_FAILS = 3;
  localparam int LOCK_LEN  = 1024;
  localparam int BASE_LAT  = 89;

  logic       clk = 1'b0;
  logic       rst_n, ena, key_valid, gate_status;
  logic [7:0] key_data;
  logic       key_ready, link_sclk, link_sdata, link_frame;
  logic       result_valid, result_granted, locked_out, busy;
  logic [1:0] fail_count;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  armed   = 0;
  int  m_fail  = 0;

  always #5 clk = ~clk;

  sentinel_key_courier dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
    .link_sclk(link_sclk), .link_sdata(link_sdata), .link_frame(link_frame),
    .gate_status(gate_status),
    .result_valid(result_valid), .result_granted(result_granted),
    .fail_count(fail_count), .locked_out(locked_out), .busy(busy)
  );

  typedef struct {
    logic [7:0] key;
    bit         status;
    bit         exp_granted;
    logic [1:0] exp_fail;
    bit         exp_lock;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction observed at negedges; cycle n = n-th negedge after the handshake edge.
  task automatic do_txn(input logic [7:0] key, input bit status, input bit exp_granted,
                        input logic [1:0] exp_fail, input bit exp_lock,
                        input int drop_at, input int drop_len,
                        input bit chain, input logic [7:0] chain_key);
    int         n;
    int         rises;
    int         exp_lat;
    int         mism;
    int         cnt;
    int         viol;
    logic [7:0] bits;
    logic       prev_sclk;
    logic       h_sclk, h_sdata, h_frame;
    exp_lat = BASE_LAT + ((drop_at > 0) ? drop_len : 0);
    if (!armed) begin
      @(negedge clk);
      key_data  = key;
      key_valid = 1'b1;
    end
    armed = 0;
    check("key_ready_idle", key_ready, 1);
    gate_status = !status;
    @(negedge clk);
    key_valid = 1'b0;
    check("frame_rise_cycle1", link_frame, 1);
    bits = 8'd0; rises = 0; prev_sclk = 1'b0;
    for (n = 1; n < 300; n++) begin
      if (link_sclk && !prev_sclk) begin
        bits = {bits[6:0], link_sdata};
        rises++;
      end
      prev_sclk = link_sclk;
      if (!link_frame) gate_status = status;
      if (result_valid) break;
      if (chain && n == exp_lat - 1) begin
        key_data  = chain_key;
        key_valid = 1'b1;
      end
      if (n == drop_at) begin
        h_sclk = link_sclk; h_sdata = link_sdata; h_frame = link_frame;
        ena  = 1'b0;
        mism = 0;
        repeat (drop_len) begin
          @(negedge clk);
          if (link_sclk !== h_sclk || link_sdata !== h_sdata ||
              link_frame !== h_frame || key_ready !== 1'b0) mism++;
        end
        ena = 1'b1;
        n += drop_len;
        check("ena_low_hold", mism, 0);
      end
      @(negedge clk);
    end
    check("result_latency", n, exp_lat);
    check("result_granted", result_granted, exp_granted);
    check("sdata_bits", bits, key);
    check("sclk_rises", rises, 8);
    check("key_ready_in_report", key_ready, 0);
    @(negedge clk);
    check("result_one_cycle", result_valid, 0);
    check("fail_count_after", fail_count, exp_fail);
    check("locked_out_after", locked_out, exp_lock);
    if (exp_lock) begin
      cnt = 0; viol = 0;
      while (locked_out && cnt < 2000) begin
        cnt++;
        if (key_ready || !busy || fail_count != 2'(MAX_FAILS)) viol++;
        key_valid = (cnt == 500);
        @(negedge clk);
      end
      key_valid = 1'b0;
      check("lockout_length", cnt, LOCK_LEN);
      check("lockout_ready_low", viol, 0);
      check("lockout_fail_clear", fail_count, 0);
      check("lockout_key_ignored", busy, 0);
    end
    check("key_ready_after", key_ready, 1);
    if (chain) armed = 1;
  endtask

  initial begin
    vec_t vecs[6];
    int   pulses;
    bit   st;
    bit   lk;
    int   da;
    int   dl;
    logic [7:0] k;

    vecs[0] = '{key: 8'hB6, status: 1'b1, exp_granted: 1'b1, exp_fail: 2'd0, exp_lock: 1'b0};
    vecs[1] = '{key: 8'h00, status: 1'b0, exp_granted: 1'b0, exp_fail: 2'd1, exp_lock: 1'b0};
    vecs[2] = '{key: 8'h00, status: 1'b0, exp_granted: 1'b0, exp_fail: 2'd2, exp_lock: 1'b0};
    vecs[3] = '{key: 8'h00, status: 1'b0, exp_granted: 1'b0, exp_fail: 2'd3, exp_lock: 1'b1};
    vecs[4] = '{key: 8'h5A, status: 1'b0, exp_granted: 1'b0, exp_fail: 2'd1, exp_lock: 1'b0};
    vecs[5] = '{key: 8'hC3, status: 1'b1, exp_granted: 1'b1, exp_fail: 2'd0, exp_lock: 1'b0};

    rst_n = 1'b0; ena = 1'b1; key_valid = 1'b0; key_data = 8'd0; gate_status = 1'b0;
    #23;
    check("rst_frame", link_frame, 0);
    check("rst_sclk", link_sclk, 0);
    check("rst_sdata", link_sdata, 0);
    check("rst_result", {result_valid, result_granted}, 0);
    check("rst_fail_lock_busy", {fail_count, locked_out, busy}, 0);
    check("rst_key_ready", key_ready, 1);
    ena = 1'b0;
    #1 check("key_ready_ena_low", key_ready, 0);
    ena = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do_txn(vecs[i].key, vecs[i].status, vecs[i].exp_granted, vecs[i].exp_fail,
             vecs[i].exp_lock, 0, 0, 1'b0, 8'h00);

    // ena dropped for 10 cycles in the middle of SHIFT
    do_txn(8'h9D, 1'b1, 1'b1, 2'd0, 1'b0, 30, 10, 1'b0, 8'h00);

    // key_valid held through REPORT: next handshake on the first IDLE cycle
    do_txn(8'h3C, 1'b1, 1'b1, 2'd0, 1'b0, 0, 0, 1'b1, 8'hA5);
    do_txn(8'hA5, 1'b0, 1'b0, 2'd1, 1'b0, 0, 0, 1'b0, 8'h00);

    // reset pulsed mid-SHIFT with one denial on record
    @(negedge clk);
    key_data = 8'hE1; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_fail", fail_count, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_link", {link_frame, link_sclk, link_sdata}, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_fail", fail_count, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (120) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("no_result_after_reset", pulses, 0);
    check("post_reset_ready", key_ready, 1);

    // randomized traffic against the consecutive-denial model
    m_fail = 0;
    for (int i = 0; i < 14; i++) begin
      k  = 8'($urandom);
      st = 1'($urandom_range(0, 1));
      da = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 70)) : 0;
      dl = int'($urandom_range(1, 8));
      if (st) m_fail = 0;
      else    m_fail = (m_fail + 1 > MAX_FAILS) ? MAX_FAILS : m_fail + 1;
      lk = (m_fail == MAX_FAILS);
      do_txn(k, st, st, 2'(m_fail), lk, da, dl, 1'b0, 8'h00);
      if (lk) m_fail = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
